// File: rtl/store_lane_align.sv
// Store-side byte-lane formatter: masks store data to size, shifts it into byte lanes,
// builds write strobes and issues one or two word-aligned write beats. Macro: MISALIGN_SPLIT_EN.
module store_lane_align #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              done,
    output logic              err,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb
);

`ifdef MISALIGN_SPLIT_EN
    typedef enum logic [2:0] {S_IDLE, S_BEAT1, S_BEAT2, S_DONE, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_BEAT1, S_DONE, S_ERR} state_t;
`endif

    function automatic logic [7:0] lane_strb(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] mask;
        case (size)
            2'b00:   mask = 4'b0001;
            2'b01:   mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
        return {4'b0000, mask} << off;
    endfunction

    function automatic logic [63:0] lane_data(input logic [31:0] data, input logic [1:0] size,
                                              input logic [1:0] off);
        logic [31:0] masked;
        case (size)
            2'b00:   masked = {24'd0, data[7:0]};
            2'b01:   masked = {16'd0, data[15:0]};
            default: masked = data;
        endcase
        return {32'd0, masked} << {off, 3'b000};
    endfunction

    state_t            state_q;
    logic              req_ready_q;
    logic              mem_valid_q;
    logic              done_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;

    logic [7:0]        wide_strb_d;
    logic [ADDR_W-1:0] beat1_addr_d;
    logic              illegal_d;

    assign wide_strb_d  = lane_strb(req_size, req_addr[1:0]);
    assign beat1_addr_d = {req_addr[ADDR_W-1:2], 2'b00};

`ifdef MISALIGN_SPLIT_EN
    logic [63:0]       wide_data_d;
    logic [ADDR_W-1:0] beat2_addr_q;
    logic [31:0]       beat2_wdata_q;
    logic [3:0]        beat2_wstrb_q;

    assign wide_data_d = lane_data(req_data, req_size, req_addr[1:0]);
    assign illegal_d   = (req_size == 2'b11);
`else
    logic [31:0]       wide_data_d;

    assign wide_data_d = 32'(lane_data(req_data, req_size, req_addr[1:0]));
    // Without the split path, any store spilling into the next word is rejected.
    assign illegal_d   = (req_size == 2'b11) || (wide_strb_d[7:4] != 4'b0000);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            mem_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
`ifdef MISALIGN_SPLIT_EN
            beat2_addr_q  <= '0;
            beat2_wdata_q <= '0;
            beat2_wstrb_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready_q <= 1'b0;
                        if (illegal_d) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end else begin
                            state_q     <= S_BEAT1;
                            mem_valid_q <= 1'b1;
                            addr_q      <= beat1_addr_d;
                            wdata_q     <= wide_data_d[31:0];
                            wstrb_q     <= wide_strb_d[3:0];
`ifdef MISALIGN_SPLIT_EN
                            beat2_addr_q  <= beat1_addr_d + ADDR_W'(4);
                            beat2_wdata_q <= wide_data_d[63:32];
                            beat2_wstrb_q <= wide_strb_d[7:4];
`endif
                        end
                    end
                end
                S_BEAT1: begin
                    if (mem_ready) begin
`ifdef MISALIGN_SPLIT_EN
                        if (beat2_wstrb_q != 4'b0000) begin
                            state_q <= S_BEAT2;
                            addr_q  <= beat2_addr_q;
                            wdata_q <= beat2_wdata_q;
                            wstrb_q <= beat2_wstrb_q;
                        end else begin
                            state_q     <= S_DONE;
                            mem_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                        end
`else
                        state_q     <= S_DONE;
                        mem_valid_q <= 1'b0;
                        done_q      <= 1'b1;
`endif
                    end
                end
`ifdef MISALIGN_SPLIT_EN
                S_BEAT2: begin
                    if (mem_ready) begin
                        state_q     <= S_DONE;
                        mem_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end
`endif
                S_DONE, S_ERR: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                    mem_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign mem_valid = mem_valid_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_store_lane_align.sv
// Randomized bench for store_lane_align: a byte-by-byte reference model groups store bytes
// into word beats; directed cases cover lane placement, splitting, stalls, wrap and reset.
module tb_store_lane_align;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        done;
    logic        err;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_addr  [2];
    logic [31:0] exp_wdata [2];
    logic [3:0]  exp_wstrb [2];
    int          exp_nb;
    bit          exp_err;

    always #5 clk = ~clk;

    store_lane_align #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .done      (done),
        .err       (err),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: walk the store's bytes one at a time, open a new beat whenever the
    // byte's word address changes, and place each byte in its lane.
    task automatic model(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
        int nbytes;
        logic [31:0] a;
        logic [31:0] w;
        int lane;
        nbytes  = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        exp_nb  = 0;
        exp_err = (size == 2'b11);
        if (!exp_err) begin
            for (int i = 0; i < nbytes; i++) begin
                a    = addr + 32'(i);
                w    = {a[31:2], 2'b00};
                lane = int'(a[1:0]);
                if (exp_nb == 0 || w != exp_addr[exp_nb-1]) begin
                    exp_addr[exp_nb]  = w;
                    exp_wdata[exp_nb] = 32'd0;
                    exp_wstrb[exp_nb] = 4'd0;
                    exp_nb++;
                end
                exp_wdata[exp_nb-1][8*lane +: 8] = data[8*i +: 8];
                exp_wstrb[exp_nb-1][lane]        = 1'b1;
            end
`ifndef MISALIGN_SPLIT_EN
            if (exp_nb > 1) exp_err = 1'b1;
`endif
        end
    endtask

    // stall < 0 picks a random 0..3 wait per beat.
    task automatic run_store(input logic [31:0] addr, input logic [31:0] data,
                             input logic [1:0] size, input int stall);
        int k;
        model(addr, data, size);
        @(negedge clk);
        check("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_data  = data;
        req_size  = size;
        mem_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_data  = $urandom;
        req_size  = 2'($urandom_range(0, 3));
        if (exp_err) begin
            @(negedge clk);
            check("err_pulse", err, 1'b1);
            check("err_no_valid", mem_valid, 1'b0);
            check("err_no_done", done, 1'b0);
            check("err_busy", req_ready, 1'b0);
            @(negedge clk);
            check("err_clear", err, 1'b0);
            check("err_idle", req_ready, 1'b1);
            check("err_no_valid2", mem_valid, 1'b0);
            return;
        end
        for (int b = 0; b < exp_nb; b++) begin
            k = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
            for (int s = 0; s <= k; s++) begin
                @(negedge clk);
                check($sformatf("b%0d_valid", b), mem_valid, 1'b1);
                check($sformatf("b%0d_addr", b), mem_addr, exp_addr[b]);
                check($sformatf("b%0d_wdata", b), mem_wdata, exp_wdata[b]);
                check($sformatf("b%0d_wstrb", b), mem_wstrb, exp_wstrb[b]);
                check("beat_busy", req_ready, 1'b0);
                check("beat_no_done", done, 1'b0);
                check("beat_no_err", err, 1'b0);
                mem_ready = (s == k);
            end
        end
        @(negedge clk);
        check("done_pulse", done, 1'b1);
        check("done_no_err", err, 1'b0);
        check("done_no_valid", mem_valid, 1'b0);
        mem_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("done_clear", done, 1'b0);
        check("done_idle", req_ready, 1'b1);
        check("idle_no_valid", mem_valid, 1'b0);
    endtask

    initial begin
        logic [31:0] ra;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = 32'd0;
        req_data  = 32'd0;
        req_size  = 2'd0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", req_ready, 1'b1);
        check("rst_valid", mem_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_wstrb", mem_wstrb, 4'd0);
        rst_n = 1'b1;

        run_store(32'h0000_1003, 32'h1234_56AA, 2'b00, 0);
        run_store(32'h0000_2002, 32'h1234_BEEF, 2'b01, 0);
        run_store(32'h0000_3001, 32'hDDCC_BBAA, 2'b10, 0);
        run_store(32'h0000_4000, 32'h0102_0304, 2'b10, 5);
        run_store(32'hFFFF_FFFF, 32'h0000_5566, 2'b01, 0);
        run_store(32'hFFFF_FFFD, 32'h8765_4321, 2'b10, 1);
        run_store(32'h0000_5000, 32'hFFFF_FFFF, 2'b11, 0);

        // Reset while the first beat is waiting on the memory.
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h0000_4000;
        req_data  = 32'hCAFE_F00D;
        req_size  = 2'b10;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("mid_valid", mem_valid, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", mem_valid, 1'b0);
        check("mid_rst_ready", req_ready, 1'b1);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_err", err, 1'b0);
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        check("post_rst_done", done, 1'b0);
        check("post_rst_valid", mem_valid, 1'b0);

        for (int t = 0; t < 300; t++) begin
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            run_store(ra, $urandom,
                      ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2)), -1);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                mem_ready = 1'($urandom_range(0, 1));
                check("gap_no_valid", mem_valid, 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
